note_lane_generator: RTL and testbench
======================================

Name: note_lane_generator

Overview:
- Upstream source of falling-note positions for the scoring stage. Maintains 5 note slots and spawns new notes at the top of the play field.
- Advances every active note by STEP pixels once per video frame. Retires notes that leave the screen.
- Drives one 10-bit vertical position per slot (pos_l1..pos_l5); these connect to the scorer's posL1..posL5 inputs. An inactive slot is parked at a position the bar can never match.

Parameters:
SCREEN_H, 480, visible field height in pixels
STEP, 2, pixels advanced per frame_tick
SPAWN_GAP, 48, frame_ticks between spawns (min 1)
PARK_POS, 10'h3FF, position driven by an idle slot

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
frame_tick  in  1  single-cycle pulse, once per video frame
run  in  1  game enabled
stop  in  1  freeze request; tied to the scorer's perdio
pos_l1..pos_l5  out  10 each  slot vertical position, or PARK_POS when idle
active  out  5  bit i = 1 when slot i+1 holds a live note
state  out  2  00 IDLE, 01 PLAY, 10 HALT
dropped  out  8  spawns lost because all slots were busy; saturates at 255

Behaviour:
- Reset (asynchronous, active-high), applied immediately:
  - state=IDLE; all pos=PARK_POS; active=0; dropped=0; gap_cnt=SPAWN_GAP-1.
- Sampling: all inputs sampled on posedge clk. Outputs are registered and change only on the cycle following an accepted event.
- FSM:
  - IDLE: run=1 -> PLAY. On entry, slots are cleared, gap_cnt=SPAWN_GAP-1 and dropped=0.
  - PLAY: stop=1 -> HALT (checked first). Else run=0 -> IDLE, with all slots parked.
  - HALT: all positions frozen; frame_tick ignored. run=0 -> IDLE with slots parked. stop deasserting does not resume play.
- Frame update, PLAY only, on the clk edge where frame_tick=1. Evaluated in this order within the same cycle:
  1. Retire: an active slot with pos+STEP > SCREEN_H-1 goes idle (pos=PARK_POS).
  2. Advance: every other active slot does pos <= pos+STEP. Arithmetic is 11-bit internally, so no wrap.
  3. Spawn: if gap_cnt==SPAWN_GAP-1, gap_cnt <= 0 and a note goes into the lowest-index idle slot (after retirement) at pos=0. If no slot is idle, dropped increments, saturating. Otherwise gap_cnt increments.
- A slot freed by retire in a cycle is reusable by the spawn in that same cycle.
- Lifetime: a note spawned on tick t sits at pos 2k on tick t+k and retires on tick t+240 (defaults). Last visible pos is 478.
- Positions are always multiples of STEP. The bar position and bar+64 used downstream must also be multiples of STEP to be matched.
- frame_tick outside PLAY has no effect and does not advance gap_cnt.
- If frame_tick and a state-changing input (stop, or run=0) arrive in the same cycle, the state change wins and no frame update occurs.

Optional Feature:
- Macro: NOTE_RANDOM_SPAWN_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset and on IDLE->PLAY) advances on every frame update in PLAY.
  - When gap_cnt==SPAWN_GAP-1, a spawn occurs only if lfsr[0]==1. Otherwise gap_cnt holds at SPAWN_GAP-1 and the spawn is retried on the next tick.
- Undefined: no LFSR logic; spawns are strictly periodic as described above.

Test Plan (macro undefined, defaults):
- reset=1, then run=1, one frame_tick -> state=PLAY; active=00001; pos_l1=0; pos_l2..l5=10'h3FF.
- 5 more ticks after the first spawn -> pos_l1=10. 48 ticks after the first spawn -> active=00011; pos_l2=0; pos_l1=96.
- Run 241 ticks from PLAY entry -> on tick 241 slot1 retires and the new spawn reuses it: pos_l1=0, active=11111, dropped=0.
- Set SPAWN_GAP=40 and run 201 ticks -> at tick 201 all 5 slots are busy; dropped=1; positions unchanged by the spawn.
- Mid-play stop=1 -> state=HALT. Further frame_ticks leave all pos frozen. run=0 -> state=IDLE; all pos=10'h3FF; active=0.
- Assert reset asynchronously mid-PLAY, between clk edges -> outputs take reset values before the next clk edge. frame_tick during reset has no effect.

Source files
------------

// File: rtl/note_lane_generator.sv
// note_lane_generator: five falling-note slots feeding the scorer.
// Each accepted frame_tick in PLAY retires notes that would leave the
// field, advances the rest by STEP pixels and spawns a new note every
// SPAWN_GAP ticks into the lowest free slot. Idle slots drive PARK_POS.
// Optional build macro NOTE_RANDOM_SPAWN_EN gates each due spawn with a
// 16-bit Fibonacci LFSR (taps 16,14,13,11), retrying on the next tick.
module note_lane_generator #(
  parameter int         SCREEN_H  = 480,
  parameter int         STEP      = 2,
  parameter int         SPAWN_GAP = 48,
  parameter logic [9:0] PARK_POS  = 10'h3FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       stop,
  output logic [9:0] pos_l1,
  output logic [9:0] pos_l2,
  output logic [9:0] pos_l3,
  output logic [9:0] pos_l4,
  output logic [9:0] pos_l5,
  output logic [4:0] active,
  output logic [1:0] state,
  output logic [7:0] dropped
);

  localparam int              GW       = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(SPAWN_GAP - 1);
  localparam logic [10:0]     LAST_ROW = 11'(SCREEN_H - 1);
  localparam logic [10:0]     STEP_W   = 11'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HALT = 2'b10
  } stateT;

  stateT          curState;
  logic [4:0][9:0] posQ;
  logic [4:0][9:0] posFrame;
  logic [4:0]      activeQ;
  logic [4:0]      activeRet;
  logic [4:0]      activeFrame;
  logic [GW-1:0]   gapCnt;
  logic [GW-1:0]   gapFrame;
  logic [7:0]      droppedQ;
  logic [7:0]      droppedFrame;
  logic            spawnDue;
  logic            spawnGo;
  logic            claimed;
  logic [10:0]     nextPos;
  logic            frameEn;

  // A frame update happens only when no state change competes with it.
  assign frameEn  = (curState == PLAY) && !stop && run && frame_tick;
  assign spawnDue = (gapCnt == GAP_LAST);

`ifdef NOTE_RANDOM_SPAWN_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;
  logic        lfsrFb;

  assign lfsrFb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign spawnGo = spawnDue & lfsr[0];

  // LFSR reseeds on reset and on play entry, steps once per frame update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if ((curState == IDLE) && run) begin
      lfsr <= LFSR_SEED;
    end else if (frameEn) begin
      lfsr <= {lfsr[14:0], lfsrFb};
    end
  end
`else
  assign spawnGo = spawnDue;
`endif

  // Next slot contents for a frame update: retire, advance, then spawn.
  always_comb begin
    posFrame     = posQ;
    activeRet    = activeQ;
    activeFrame  = activeQ;
    claimed      = 1'b0;
    nextPos      = '0;
    for (int i = 0; i < 5; i++) begin
      nextPos = {1'b0, posQ[i]} + STEP_W;
      if (activeQ[i]) begin
        if (nextPos > LAST_ROW) begin
          posFrame[i]  = PARK_POS;
          activeRet[i] = 1'b0;
        end else begin
          posFrame[i] = nextPos[9:0];
        end
      end
    end
    activeFrame = activeRet;
    // Lowest-index slot that is idle after retirement takes the new note.
    for (int i = 0; i < 5; i++) begin
      if (spawnGo && !claimed && !activeRet[i]) begin
        posFrame[i]    = '0;
        activeFrame[i] = 1'b1;
        claimed        = 1'b1;
      end
    end
    if (spawnGo) begin
      gapFrame = '0;
    end else if (spawnDue) begin
      gapFrame = gapCnt;
    end else begin
      gapFrame = gapCnt + 1'b1;
    end
    if (spawnGo && !claimed && (droppedQ != 8'hFF)) begin
      droppedFrame = droppedQ + 8'd1;
    end else begin
      droppedFrame = droppedQ;
    end
  end

  // Control FSM and slot registers; stop has priority over run in PLAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState <= IDLE;
      posQ     <= {5{PARK_POS}};
      activeQ  <= '0;
      gapCnt   <= GAP_LAST;
      droppedQ <= '0;
    end else begin
      unique case (curState)
        IDLE: begin
          if (run) begin
            curState <= PLAY;
            posQ     <= {5{PARK_POS}};
            activeQ  <= '0;
            gapCnt   <= GAP_LAST;
            droppedQ <= '0;
          end
        end
        PLAY: begin
          if (stop) begin
            curState <= HALT;
          end else if (!run) begin
            curState <= IDLE;
            posQ     <= {5{PARK_POS}};
            activeQ  <= '0;
          end else if (frame_tick) begin
            posQ     <= posFrame;
            activeQ  <= activeFrame;
            gapCnt   <= gapFrame;
            droppedQ <= droppedFrame;
          end
        end
        HALT: begin
          if (!run) begin
            curState <= IDLE;
            posQ     <= {5{PARK_POS}};
            activeQ  <= '0;
          end
        end
        default: begin
          curState <= IDLE;
        end
      endcase
    end
  end

  assign pos_l1  = posQ[0];
  assign pos_l2  = posQ[1];
  assign pos_l3  = posQ[2];
  assign pos_l4  = posQ[3];
  assign pos_l5  = posQ[4];
  assign active  = activeQ;
  assign state   = curState;
  assign dropped = droppedQ;

endmodule

// File: tb/tb_note_lane_generator.sv
// Testbench for note_lane_generator: a default instance and one built
// with SPAWN_GAP=40 share all stimulus. Directed vectors push expected
// values into a queue; a monitor drains and compares them.
module tb_note_lane_generator;

  logic clk;
  logic reset;
  logic frameTick;
  logic run;
  logic stop;

  logic [4:0][9:0] posA;
  logic [4:0]      activeA;
  logic [1:0]      stateA;
  logic [7:0]      droppedA;

  logic [4:0][9:0] posB;
  logic [4:0]      activeB;
  logic [1:0]      stateB;
  logic [7:0]      droppedB;

  // Expected entries: {id[7:0], value[15:0]}.
  logic [23:0] expQ[$];
  int          checks = 0;
  int          fails  = 0;
  event        checkEv;

  note_lane_generator dut (
    .clk(clk), .reset(reset), .frame_tick(frameTick), .run(run), .stop(stop),
    .pos_l1(posA[0]), .pos_l2(posA[1]), .pos_l3(posA[2]), .pos_l4(posA[3]), .pos_l5(posA[4]),
    .active(activeA), .state(stateA), .dropped(droppedA)
  );

  note_lane_generator #(.SPAWN_GAP(40)) dut40 (
    .clk(clk), .reset(reset), .frame_tick(frameTick), .run(run), .stop(stop),
    .pos_l1(posB[0]), .pos_l2(posB[1]), .pos_l3(posB[2]), .pos_l4(posB[3]), .pos_l5(posB[4]),
    .active(activeB), .state(stateB), .dropped(droppedB)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  localparam logic [7:0] ID_STATE = 8'd0, ID_ACT = 8'd1, ID_DROP = 8'd2, ID_POS = 8'd3;
  localparam logic [7:0] ID_STATE40 = 8'd8, ID_ACT40 = 8'd9, ID_DROP40 = 8'd10, ID_POS40 = 8'd11;

  function automatic logic [15:0] actualOf(input logic [7:0] id);
    case (id)
      ID_STATE:   return {14'd0, stateA};
      ID_ACT:     return {11'd0, activeA};
      ID_DROP:    return {8'd0, droppedA};
      ID_STATE40: return {14'd0, stateB};
      ID_ACT40:   return {11'd0, activeB};
      ID_DROP40:  return {8'd0, droppedB};
      default: begin
        if (id >= ID_POS && id < ID_POS + 8'd5) return {6'd0, posA[id - ID_POS]};
        if (id >= ID_POS40 && id < ID_POS40 + 8'd5) return {6'd0, posB[id - ID_POS40]};
        return 16'hDEAD;
      end
    endcase
  endfunction

  function automatic string nameOf(input logic [7:0] id);
    case (id)
      ID_STATE:   return "state";
      ID_ACT:     return "active";
      ID_DROP:    return "dropped";
      ID_STATE40: return "gap40.state";
      ID_ACT40:   return "gap40.active";
      ID_DROP40:  return "gap40.dropped";
      default: begin
        if (id >= ID_POS && id < ID_POS + 8'd5) return $sformatf("pos_l%0d", id - ID_POS + 1);
        if (id >= ID_POS40 && id < ID_POS40 + 8'd5) return $sformatf("gap40.pos_l%0d", id - ID_POS40 + 1);
        return "unknown";
      end
    endcase
  endfunction

  // Scoreboard monitor: drains every pending expectation when signalled.
  initial begin
    logic [23:0] e;
    logic [15:0] act;
    forever begin
      @(checkEv);
      #1;
      while (expQ.size() > 0) begin
        e   = expQ.pop_front();
        act = actualOf(e[23:16]);
        checks++;
        if (act !== e[15:0]) begin
          fails++;
          $display("FAIL %s: got %0h, expected %0h (t=%0t)", nameOf(e[23:16]), act, e[15:0], $time);
        end
      end
    end
  end

  // Driver tasks
  task automatic expectV(input logic [7:0] id, input logic [15:0] v);
    expQ.push_back({id, v});
  endtask

  task automatic expectPos(input logic [7:0] base, input logic [9:0] p1, input logic [9:0] p2,
                           input logic [9:0] p3, input logic [9:0] p4, input logic [9:0] p5);
    expectV(base,        {6'd0, p1});
    expectV(base + 8'd1, {6'd0, p2});
    expectV(base + 8'd2, {6'd0, p3});
    expectV(base + 8'd3, {6'd0, p4});
    expectV(base + 8'd4, {6'd0, p5});
  endtask

  task automatic checkNow();
    -> checkEv;
    #2;
  endtask

  // Called at a negedge; each tick is a one-cycle frame_tick pulse.
  task automatic tickN(input int n);
    repeat (n) begin
      frameTick = 1'b1;
      @(negedge clk);
      frameTick = 1'b0;
      @(negedge clk);
    end
  endtask

  localparam logic [9:0] PK = 10'h3FF;

  // Directed stimulus
  initial begin
    reset = 1'b1; run = 1'b0; stop = 1'b0; frameTick = 1'b0;
    repeat (3) @(negedge clk);
    expectV(ID_STATE, 16'd0); expectV(ID_ACT, 16'd0); expectV(ID_DROP, 16'd0);
    expectPos(ID_POS, PK, PK, PK, PK, PK);
    checkNow();

    reset = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    expectV(ID_STATE, 16'd1); expectV(ID_ACT, 16'd0);
    checkNow();

    tickN(1);    // tick 1: first spawn
    expectV(ID_STATE, 16'd1); expectV(ID_ACT, 16'h01);
    expectPos(ID_POS, 10'd0, PK, PK, PK, PK);
    expectV(ID_ACT40, 16'h01);
    checkNow();

    tickN(5);    // tick 6
    expectV(ID_POS, 16'd10);
    checkNow();

    tickN(42);   // tick 48: default not yet due, gap40 spawned at 41
    expectV(ID_POS, 16'd94); expectV(ID_ACT, 16'h01);
    expectV(ID_ACT40, 16'h03); expectV(ID_POS40 + 8'd1, 16'd14);
    checkNow();

    tickN(1);    // tick 49
    expectV(ID_ACT, 16'h03); expectV(ID_POS, 16'd96); expectV(ID_POS + 8'd1, 16'd0);
    checkNow();

    tickN(151);  // tick 200
    expectV(ID_ACT40, 16'h1F); expectV(ID_DROP40, 16'd0); expectV(ID_POS40, 16'd398);
    checkNow();

    tickN(1);    // tick 201: gap40 has no free slot
    expectV(ID_DROP40, 16'd1); expectV(ID_ACT40, 16'h1F);
    expectPos(ID_POS40, 10'd400, 10'd320, 10'd240, 10'd160, 10'd80);
    checkNow();

    tickN(39);   // tick 240: last visible row
    expectV(ID_POS, 16'd478); expectV(ID_ACT, 16'h1F); expectV(ID_DROP, 16'd0);
    checkNow();

    tickN(1);    // tick 241: slot1 retires and is reused
    expectV(ID_ACT, 16'h1F); expectV(ID_DROP, 16'd0);
    expectPos(ID_POS, 10'd0, 10'd384, 10'd288, 10'd192, 10'd96);
    expectV(ID_DROP40, 16'd1); expectV(ID_POS40, 16'd0);
    checkNow();

    // stop together with frame_tick: stop wins, no update
    stop = 1'b1; frameTick = 1'b1;
    @(negedge clk);
    stop = 1'b0; frameTick = 1'b0;
    expectV(ID_STATE, 16'd2); expectV(ID_STATE40, 16'd2);
    expectPos(ID_POS, 10'd0, 10'd384, 10'd288, 10'd192, 10'd96);
    checkNow();

    tickN(3);    // frozen, and stop release does not resume
    expectV(ID_STATE, 16'd2); expectV(ID_ACT, 16'h1F);
    expectPos(ID_POS, 10'd0, 10'd384, 10'd288, 10'd192, 10'd96);
    checkNow();

    run = 1'b0;
    @(negedge clk);
    expectV(ID_STATE, 16'd0); expectV(ID_ACT, 16'd0);
    expectPos(ID_POS, PK, PK, PK, PK, PK);
    expectV(ID_DROP40, 16'd1); expectV(ID_ACT40, 16'd0);
    checkNow();

    tickN(2);    // ticks in IDLE do nothing
    expectV(ID_STATE, 16'd0); expectV(ID_ACT, 16'd0); expectV(ID_POS, {6'd0, PK});
    checkNow();

    run = 1'b1;
    @(negedge clk);
    expectV(ID_STATE, 16'd1); expectV(ID_DROP40, 16'd0); expectV(ID_ACT, 16'd0);
    checkNow();

    tickN(2);
    expectV(ID_ACT, 16'h01); expectV(ID_POS, 16'd2);
    checkNow();

    // run=0 with frame_tick: leave to IDLE, slots parked
    run = 1'b0; frameTick = 1'b1;
    @(negedge clk);
    frameTick = 1'b0;
    expectV(ID_STATE, 16'd0); expectV(ID_ACT, 16'd0); expectV(ID_POS, {6'd0, PK});
    checkNow();

    // Asynchronous reset mid-PLAY, between clock edges
    run = 1'b1;
    @(negedge clk);
    tickN(3);
    expectV(ID_POS, 16'd4); expectV(ID_ACT, 16'h01);
    checkNow();
    @(posedge clk);
    #3;
    reset = 1'b1; frameTick = 1'b1;
    expectV(ID_STATE, 16'd0); expectV(ID_ACT, 16'd0); expectV(ID_DROP, 16'd0);
    expectPos(ID_POS, PK, PK, PK, PK, PK);
    checkNow();
    @(posedge clk);
    @(negedge clk);
    expectV(ID_STATE, 16'd0); expectV(ID_ACT, 16'd0); expectV(ID_POS, {6'd0, PK});
    checkNow();
    reset = 1'b0; frameTick = 1'b0; run = 1'b0;
    @(negedge clk);
    expectV(ID_STATE, 16'd0); expectV(ID_ACT40, 16'd0);
    checkNow();

    // Final report
    @(negedge clk);
    #3;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: got %0d pending entries, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
